// File: rtl/sklansky_mp_seq.sv
// Multi-precision add/subtract that reuses one 16-bit Sklansky adder, one word per cycle, LSW first.
// Result valid WORDS cycles after the accepting edge; one op in flight, held in DONE until out_ready.

module sklansky16 (
  input  logic        ci,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        co
);
  logic [15:0] p;
  logic [15:0] g  [0:4];
  logic [15:0] pp [0:4];

  always_comb begin
    p = a ^ b;
    for (int l = 0; l < 5; l++) begin
      g[l]  = '0;
      pp[l] = '0;
    end
    // Carry-in folded into bit 0 generate so prefix G[i] is the carry out of bit i.
    g[0]    = a & b;
    g[0][0] = (a[0] & b[0]) | (p[0] & ci);
    pp[0]   = p;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (i[l]) begin
          g[l+1][i]  = g[l][i] | (pp[l][i] & g[l][((i >> l) << l) - 1]);
          pp[l+1][i] = pp[l][i] & pp[l][((i >> l) << l) - 1];
        end else begin
          g[l+1][i]  = g[l][i];
          pp[l+1][i] = pp[l][i];
        end
      end
    end
    s  = p ^ {g[4][14:0], ci};
    co = g[4][15];
  end
endmodule

module sklansky_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);
  localparam int N     = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               op_sub_q, op_sub_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [N-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [15:0]        add_a, add_b, add_s;
  logic               add_ci, add_co;

  sklansky16 u_add (
    .ci (add_ci),
    .a  (add_a),
    .b  (add_b),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_sub_d = op_sub_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a    = '0;
    add_b    = '0;
    add_ci   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_sub_d = op_sub;
          carry_d  = op_sub;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Subtract is A + ~B + 1, the +1 coming from the preloaded carry.
        add_a  = a_q[idx_q*16 +: 16];
        add_b  = b_q[idx_q*16 +: 16] ^ {16{op_sub_q}};
        add_ci = carry_q;
        sum_d[idx_q*16 +: 16] = add_s;
        carry_d = add_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          cout_d  = add_co;
          ovf_d   = (a_q[N-1] == add_b[15]) && (add_s[15] != a_q[N-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_sub_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_sub_q <= op_sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_sklansky_mp_seq.sv
// Directed bench for sklansky_mp_seq (WORDS = 4) with an arithmetic reference model and scoreboard.

module tb_sklansky_mp_seq;
  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [N-1:0] sum;

  int total = 0;
  int bad   = 0;
  logic [N+1:0] exp_q[$];

  sklansky_mp_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: plain N-bit arithmetic; returns {ovf, cout, sum}.
  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic sub);
    logic [N:0] r;
    logic       c, v;
    if (sub) begin
      r = {1'b0, x} - {1'b0, y};
      c = (x >= y);
      v = (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
    end else begin
      r = {1'b0, x} + {1'b0, y};
      c = r[N];
      v = (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
    end
    return {v, c, r[N-1:0]};
  endfunction

  // Scoreboard: every DONE cycle must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk1("stray_out_valid", out_valid, 1'b0);
      end else begin
        chk("model_sum", sum, exp_q[0][N-1:0]);
        chk1("model_cout", cout, exp_q[0][N]);
        chk1("model_ovf", ovf, exp_q[0][N+1]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic sub);
    int w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk1("in_ready_before_accept", in_ready, 1'b1);
    a        = ai;
    b        = bi;
    op_sub   = sub;
    in_valid = 1'b1;
    exp_q.push_back(model(ai, bi, sub));
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic sub,
                       input int hold, input logic [N-1:0] e_sum, input logic e_cout,
                       input logic e_ovf);
    logic [N+1:0] m;
    logic [N-1:0] s0;
    int lat;
    m = model(ai, bi, sub);
    chk("pin_model_sum", m[N-1:0], e_sum);
    chk1("pin_model_cout", m[N], e_cout);
    chk1("pin_model_ovf", m[N+1], e_ovf);
    out_ready = (hold == 0);
    start_op(ai, bi, sub);
    // Requests during RUN must be ignored.
    in_valid = 1'b1;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      step();
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(WORDS + 1));
    chk("dut_sum", sum, e_sum);
    chk1("dut_cout", cout, e_cout);
    chk1("dut_ovf", ovf, e_ovf);
    s0 = sum;
    for (int i = 0; i < hold; i++) begin
      step();
      in_valid = (i % 2 == 0);
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_sum_stable", sum, s0);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    if (hold > 0) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk1("in_ready_after_done", in_ready, 1'b1);
    chk1("out_valid_after_done", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_sum", sum, 64'h0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    do_op(64'h0000_0000_0000_59DF, 64'h0000_0000_0000_BCD6, 1'b0, 0,
          64'h0000_0000_0001_16B5, 1'b0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 64'h0, 1'b1, 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 3, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op(64'h0, 64'h1, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_op(64'h5, 64'h3, 1'b1, 1, 64'h2, 1'b1, 1'b0);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 0,
          64'h2222_2222_2222_2211, 1'b0, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2, 64'h0, 1'b1, 1'b1);

    // Abort in the second RUN cycle; the aborted request must never complete.
    out_ready = 1'b1;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk("abort_sum", sum, 64'h0);
    chk1("abort_cout", cout, 1'b0);
    chk1("abort_ovf", ovf, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk1("abort_no_result", out_valid, 1'b0);
    end
    out_ready = 1'b0;
    step();
    do_op(64'h5, 64'h3, 1'b1, 0, 64'h2, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) step();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
